// File: rtl/rgb_fade_sequencer.sv
// RGB LED colour show: holds each palette colour, then cross-fades linearly to the next,
// and drives the three LED PWM outputs directly.
//
// state | meaning
// IDLE  | LED blanked, color_idx retained, waiting for en
// HOLD  | palette[color_idx] shown for HOLD_CYCLES unpaused cycles
// FADE  | duties stepping 1 LSB every FADE_STEP_CYCLES toward palette[next]
module rgb_fade_sequencer #(
    parameter int HOLD_CYCLES      = 250000000,
    parameter int FADE_STEP_CYCLES = 390625
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pause,
    input  logic       skip,
    output logic [7:0] R_duty,
    output logic [7:0] G_duty,
    output logic [7:0] B_duty,
    output logic [2:0] color_idx,
    output logic       fading,
    output logic       R_pwm,
    output logic       G_pwm,
    output logic       B_pwm
);

    typedef enum logic [1:0] {IDLE, HOLD, FADE} state_t;

    localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);
    localparam logic [27:0] STEP_LAST = 28'(FADE_STEP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  idx_nxt;
    logic [7:0]  r_nxt, g_nxt, b_nxt;
    logic [27:0] hold_cnt, hold_nxt;
    logic [27:0] step_cnt, step_nxt;
    logic [7:0]  pwm_cnt;
    logic [23:0] cur_rgb, tgt_rgb;
    logic        at_target;

    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd1:    return {8'd255, 8'd97,  8'd0};
            3'd2:    return {8'd255, 8'd255, 8'd0};
            3'd3:    return {8'd0,   8'd255, 8'd0};
            3'd4:    return {8'd0,   8'd0,   8'd255};
            3'd5:    return {8'd8,   8'd46,  8'd84};
            3'd6:    return {8'd160, 8'd32,  8'd240};
            default: return {8'd255, 8'd0,   8'd0};
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) return cur + 8'd1;
        if (cur > tgt) return cur - 8'd1;
        return cur;
    endfunction

    assign cur_rgb   = palette(color_idx);
    assign tgt_rgb   = palette(next_idx(color_idx));
    assign at_target = ({R_duty, G_duty, B_duty} == tgt_rgb);

    always_comb begin
        state_nxt = state;
        idx_nxt   = color_idx;
        r_nxt     = R_duty;
        g_nxt     = G_duty;
        b_nxt     = B_duty;
        hold_nxt  = hold_cnt;
        step_nxt  = step_cnt;
        if (!en) begin
            state_nxt = IDLE;
            r_nxt     = 8'd0;
            g_nxt     = 8'd0;
            b_nxt     = 8'd0;
            hold_nxt  = 28'd0;
            step_nxt  = 28'd0;
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    state_nxt             = HOLD;
                    {r_nxt, g_nxt, b_nxt} = cur_rgb;
                    hold_nxt              = 28'd0;
                end
                HOLD: begin
                    if (skip || hold_cnt == HOLD_LAST) begin
                        state_nxt = FADE;
                        step_nxt  = 28'd0;
                    end else begin
                        hold_nxt = hold_cnt + 28'd1;
                    end
                end
                FADE: begin
                    // skip and natural completion both land on the target exactly once
                    if (skip || at_target) begin
                        state_nxt             = HOLD;
                        {r_nxt, g_nxt, b_nxt} = tgt_rgb;
                        idx_nxt               = next_idx(color_idx);
                        hold_nxt              = 28'd0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_nxt = 28'd0;
                        r_nxt    = step_toward(R_duty, tgt_rgb[23:16]);
                        g_nxt    = step_toward(G_duty, tgt_rgb[15:8]);
                        b_nxt    = step_toward(B_duty, tgt_rgb[7:0]);
                    end else begin
                        step_nxt = step_cnt + 28'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            color_idx <= 3'd0;
            R_duty    <= 8'd0;
            G_duty    <= 8'd0;
            B_duty    <= 8'd0;
            hold_cnt  <= 28'd0;
            step_cnt  <= 28'd0;
            fading    <= 1'b0;
        end else begin
            state     <= state_nxt;
            color_idx <= idx_nxt;
            R_duty    <= r_nxt;
            G_duty    <= g_nxt;
            B_duty    <= b_nxt;
            hold_cnt  <= hold_nxt;
            step_cnt  <= step_nxt;
            fading    <= (state_nxt == FADE);
        end
    end

    // 255-cycle period so duty 255 compares true on every count value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= 8'd0;
            R_pwm   <= 1'b0;
            G_pwm   <= 1'b0;
            B_pwm   <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
            R_pwm   <= (pwm_cnt < R_duty);
            G_pwm   <= (pwm_cnt < G_duty);
            B_pwm   <= (pwm_cnt < B_duty);
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with HOLD_CYCLES=4, FADE_STEP_CYCLES=2.
module tb_rgb_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, pause = 1'b0, skip = 1'b0;
    logic [7:0] R_duty, G_duty, B_duty;
    logic [2:0] color_idx;
    logic       fading, R_pwm, G_pwm, B_pwm;
    logic [23:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_fade_sequencer #(.HOLD_CYCLES(4), .FADE_STEP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .pause(pause), .skip(skip),
        .R_duty(R_duty), .G_duty(G_duty), .B_duty(B_duty),
        .color_idx(color_idx), .fading(fading),
        .R_pwm(R_pwm), .G_pwm(G_pwm), .B_pwm(B_pwm)
    );

    always #5 clk = ~clk;
    assign rgb = {R_duty, G_duty, B_duty};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_skip();
        skip = 1'b1;
        tick();
        skip = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; pause = 1'b0; skip = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (rgb !== 24'h0) begin n_fail++; $display("FAIL reset_duty: got %h want 000000", rgb); end
        n_checks++;
        if ({color_idx, fading, R_pwm, G_pwm, B_pwm} !== 7'b0) begin
            n_fail++; $display("FAIL reset_misc: idx %0d fading %b pwm %b%b%b want all 0", color_idx, fading, R_pwm, G_pwm, B_pwm);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_fade();
        int n = 0;
        int guard = 0;
        en = 1'b1;
        tick();
        n_checks++;
        if ({rgb, color_idx, fading} !== {24'hFF0000, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL enable_load: got %h idx %0d fading %b want ff0000 idx 0 fading 0", rgb, color_idx, fading);
        end
        repeat (3) tick();
        n_checks++;
        if (fading !== 1'b0) begin n_fail++; $display("FAIL hold_early: fading %b want 0", fading); end
        tick();
        n_checks++;
        if (fading !== 1'b1) begin n_fail++; $display("FAIL hold_expiry: fading %b want 1", fading); end
        while (fading === 1'b1 && guard < 2000) begin
            n++;
            if (n == 11) begin
                n_checks++;
                if (G_duty !== 8'd5) begin n_fail++; $display("FAIL fade_ramp: G %0d want 5", G_duty); end
            end
            tick();
            guard++;
        end
        n_checks++;
        if (n != 195) begin n_fail++; $display("FAIL fade_len: got %0d cycles want 195", n); end
        n_checks++;
        if ({rgb, color_idx, fading} !== {24'hFF6100, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL fade_done: got %h idx %0d fading %b want ff6100 idx 1 fading 0", rgb, color_idx, fading);
        end
    endtask

    task automatic test_skip();
        pulse_skip();
        pulse_skip();
        n_checks++;
        if ({rgb, color_idx} !== {24'hFFFF00, 3'd2}) begin
            n_fail++; $display("FAIL skip_to_idx2: got %h idx %0d want ffff00 idx 2", rgb, color_idx);
        end
        tick();
        pulse_skip();
        n_checks++;
        if ({fading, color_idx} !== {1'b1, 3'd2}) begin
            n_fail++; $display("FAIL skip_hold: fading %b idx %0d want 1 idx 2", fading, color_idx);
        end
        repeat (5) tick();
        n_checks++;
        if (rgb !== {8'd253, 8'd255, 8'd0}) begin n_fail++; $display("FAIL fade_down: got %h want fdff00", rgb); end
        pulse_skip();
        n_checks++;
        if ({rgb, color_idx, fading} !== {24'h00FF00, 3'd3, 1'b0}) begin
            n_fail++; $display("FAIL skip_fade: got %h idx %0d fading %b want 00ff00 idx 3 fading 0", rgb, color_idx, fading);
        end
    endtask

    task automatic test_enable();
        pulse_skip();
        pulse_skip();
        pulse_skip();
        repeat (3) tick();
        en = 1'b0;
        tick();
        n_checks++;
        if ({rgb, color_idx, fading} !== {24'h0, 3'd4, 1'b0}) begin
            n_fail++; $display("FAIL disable: got %h idx %0d fading %b want 000000 idx 4 fading 0", rgb, color_idx, fading);
        end
        repeat (3) tick();
        n_checks++;
        if (rgb !== 24'h0) begin n_fail++; $display("FAIL idle_blank: got %h want 000000", rgb); end
        en = 1'b1;
        tick();
        n_checks++;
        if ({rgb, color_idx, fading} !== {24'h0000FF, 3'd4, 1'b0}) begin
            n_fail++; $display("FAIL reenable: got %h idx %0d fading %b want 0000ff idx 4 fading 0", rgb, color_idx, fading);
        end
    endtask

    task automatic test_pause();
        repeat (4) tick();
        n_checks++;
        if (fading !== 1'b1) begin n_fail++; $display("FAIL pause_pre: fading %b want 1", fading); end
        repeat (4) tick();
        n_checks++;
        if (rgb !== {8'd2, 8'd2, 8'd253}) begin n_fail++; $display("FAIL pause_start: got %h want 0202fd", rgb); end
        pause = 1'b1;
        repeat (20) tick();
        skip = 1'b1;
        tick();
        skip = 1'b0;
        repeat (29) tick();
        n_checks++;
        if ({rgb, color_idx, fading} !== {8'd2, 8'd2, 8'd253, 3'd4, 1'b1}) begin
            n_fail++; $display("FAIL pause_frozen: got %h idx %0d fading %b want 0202fd idx 4 fading 1", rgb, color_idx, fading);
        end
        pause = 1'b0;
        tick();
        n_checks++;
        if (rgb !== {8'd2, 8'd2, 8'd253}) begin n_fail++; $display("FAIL resume_phase: got %h want 0202fd", rgb); end
        tick();
        n_checks++;
        if (rgb !== {8'd3, 8'd3, 8'd252}) begin n_fail++; $display("FAIL resume_step: got %h want 0303fc", rgb); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rgb, color_idx, fading, R_pwm, G_pwm, B_pwm} !== 31'b0) begin
            n_fail++; $display("FAIL async_reset: got %h idx %0d fading %b pwm %b%b%b want all 0", rgb, color_idx, fading, R_pwm, G_pwm, B_pwm);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_wrap();
        int n = 0;
        int guard = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            pulse_skip();
            pulse_skip();
        end
        n_checks++;
        if ({rgb, color_idx} !== {24'hA020F0, 3'd6}) begin
            n_fail++; $display("FAIL wrap_start: got %h idx %0d want a020f0 idx 6", rgb, color_idx);
        end
        while (fading !== 1'b1 && guard < 20) begin tick(); guard++; end
        guard = 0;
        while (fading === 1'b1 && guard < 2000) begin n++; tick(); guard++; end
        n_checks++;
        if (n != 481) begin n_fail++; $display("FAIL wrap_len: got %0d cycles want 481", n); end
        n_checks++;
        if ({rgb, color_idx} !== {24'hFF0000, 3'd0}) begin
            n_fail++; $display("FAIL wrap_done: got %h idx %0d want ff0000 idx 0", rgb, color_idx);
        end
    endtask

    task automatic test_pwm();
        int r_hi = 0, g_hi = 0, b_hi = 0;
        pulse_skip();
        pulse_skip();
        pause = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 255; i++) begin
            tick();
            r_hi += int'(R_pwm);
            g_hi += int'(G_pwm);
            b_hi += int'(B_pwm);
        end
        n_checks++;
        if (g_hi != 97) begin n_fail++; $display("FAIL pwm_g97: high %0d cycles want 97", g_hi); end
        n_checks++;
        if (r_hi != 255) begin n_fail++; $display("FAIL pwm_r255: high %0d cycles want 255", r_hi); end
        n_checks++;
        if (b_hi != 0) begin n_fail++; $display("FAIL pwm_b0: high %0d cycles want 0", b_hi); end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fade();
        test_skip();
        test_enable();
        test_pause();
        test_async_reset();
        test_wrap();
        test_pwm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Autonomous colour-show controller for the board RGB LED. Steps through a fixed seven-entry palette, holding each colour for a programmable time and then cross-fading linearly to the next. It generates the three LED PWM drive signals itself. It sits between the board switches/buttons (enable, pause, skip) and the LED pins, and replaces the hard-switched colour decoder with smooth transitions.

## Interface

- HOLD_CYCLES, 250000000: clock cycles each palette colour is held; legal range 1..2^28-1.
- FADE_STEP_CYCLES, 390625: clock cycles between successive 1-LSB duty steps during a fade; legal range 1..2^28-1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  level; 1 runs the show, 0 blanks the LED.
- pause  in  1  level; 1 freezes all hold and fade counters and duties.
- skip  in  1  single-cycle pulse; ends the current hold or fade early.
- R_duty, G_duty, B_duty  out  8 each  current duty per channel (0 = off, 255 = fully on).
- color_idx  out  3  index of the palette entry currently held or being faded from.
- fading  out  1  1 while in FADE.
- R_pwm, G_pwm, B_pwm  out  1 each  registered PWM drive.

## Operation

- Palette (R,G,B):
  - 0 = (255,0,0)
  - 1 = (255,97,0)
  - 2 = (255,255,0)
  - 3 = (0,255,0)
  - 4 = (0,0,255)
  - 5 = (8,46,84)
  - 6 = (160,32,240)
- next(idx) = idx+1, with 6 wrapping to 0. Index 7 is never reachable.
- States are IDLE, HOLD and FADE.
- IDLE:
  - Duties are 0 and color_idx is retained.
  - en=1 moves to HOLD, loading the duties with palette[color_idx] and clearing the hold counter.
- HOLD:
  - The hold counter increments each unpaused cycle.
  - Exits to FADE when counter == HOLD_CYCLES-1 or skip=1; the step counter is cleared on entry to FADE.
- FADE:
  - The target is palette[next(color_idx)].
  - If all three duties equal the target, go to HOLD: color_idx <= next, and the hold counter is cleared.
  - Otherwise the step counter increments. When it reaches FADE_STEP_CYCLES-1 it wraps to 0, and every channel not at target moves 1 LSB toward it. There is no overshoot.
  - skip=1 snaps the duties to the target, sets color_idx <= next, and goes to HOLD on the same edge.
- en=0 in any state takes priority over everything:
  - Next state is IDLE.
  - Duties become 0 on the next edge.
  - Counters are cleared.
  - color_idx is kept.
- pause=1, with en=1, freezes state, counters and duties; skip is ignored while paused. PWM keeps running.
- Priority: rst > en=0 > pause > skip > normal counting.
- PWM:
  - A free-running 8-bit counter counts 0..254 and wraps to 0, giving a period of 255 cycles.
  - X_pwm <= (pwm_cnt < X_duty).
  - Duty 0 gives a constant 0 and duty 255 gives a constant 1.
  - The PWM counter runs regardless of en or pause.
- Hold and step counters are 28 bits wide; comparisons use the full width.

## Timing

- Reset (async assert) values:
  - State IDLE, color_idx 0.
  - All duties 0, all pwm outputs 0, fading 0.
  - PWM counter 0, hold and step counters 0.
- Release of rst is sampled synchronously; the first active edge follows.
- en sampled 1 in IDLE: duties equal palette[color_idx] on the following cycle (1-cycle latency).
- A HOLD lasts exactly HOLD_CYCLES unpaused cycles.
- A FADE whose largest channel distance is D lasts D*FADE_STEP_CYCLES+1 cycles. D=0 is not possible, because adjacent palette entries differ.
- fading is registered and is 1 exactly during the FADE cycles.
- pwm outputs lag the duty/counter compare by 1 cycle.
- skip coinciding with the natural HOLD expiry has the same effect as the expiry alone.
- skip coinciding with a FADE step or completion produces a single snap; idx advances once.

## Test plan

- Reset, en=1, HOLD_CYCLES=4, FADE_STEP_CYCLES=2:
  - One cycle later: duties (255,0,0), idx 0, fading 0.
  - After 4 cycles: fading=1.
  - G rises 1 per 2 cycles to 97, 195 FADE cycles in total.
  - Then HOLD with idx 1 and duties (255,97,0).
- Wrap, same parameters, starting in HOLD at idx 6:
  - The fade goes (160,32,240) -> (255,0,0) with D=240, lasting 481 cycles.
  - idx becomes 0.
- skip pulse mid-HOLD at idx 2: FADE next cycle. skip pulse mid-FADE toward idx 3: duties (0,255,0), idx 3 and HOLD on the next edge.
- en=0 mid-FADE at idx 4: duties 0 and fading 0 next cycle, idx stays 4. Re-enable: duties (0,0,255) one cycle later.
- pause=1 for 50 cycles mid-fade: duties and fading are unchanged and skip is ignored. Release resumes the step count exactly where it stopped.
- Duty 97 on G: G_pwm is high 97 of every 255 cycles. Duty 255 is a constant 1, duty 0 a constant 0. Async rst low mid-fade: all outputs are 0 immediately, without waiting for a clock edge.
